// File: rtl/ysyx_210544_intr_ctrl.sv
// Machine-timer interrupt controller that sits downstream of the CLINT.
// It waits for a commit boundary before raising a trap request, and blocks new requests until mret.
module ysyx_210544_intr_ctrl #(
    parameter logic [63:0] CAUSE_MTI = 64'h8000_0000_0000_0007
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_mtime_overflow,
    input  logic        i_csr_mstatus_mie,
    input  logic        i_csr_mie_mtie,
    input  logic        i_inst_commit,
    input  logic [63:0] i_commit_next_pc,
    input  logic        i_trap_ack,
    input  logic        i_mret,
    output logic        o_mip_mtip,
    output logic        o_trap_req,
    output logic [63:0] o_trap_cause,
    output logic [63:0] o_trap_epc,
    output logic        o_in_service,
    output logic [31:0] o_intr_count
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        REQ   = 2'd2,
        INSVC = 2'd3
    } state_t;

    state_t      state;
    logic [63:0] epc_q;
    logic [31:0] count_q;
    logic        pend;

    // Pending uses the registered mtip, so the overflow needs two cycles to reach ARMED.
    assign pend         = o_mip_mtip & i_csr_mstatus_mie & i_csr_mie_mtie;
    assign o_intr_count = count_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            o_mip_mtip   <= 1'b0;
            o_trap_req   <= 1'b0;
            o_trap_cause <= 64'd0;
            o_trap_epc   <= 64'd0;
            o_in_service <= 1'b0;
            epc_q        <= 64'd0;
            count_q      <= 32'd0;
        end else begin
            o_mip_mtip <= i_mtime_overflow;
            case (state)
                IDLE: begin
                    if (pend) begin
                        state <= ARMED;
                    end
                end
                ARMED: begin
                    // Losing the enable wins over a coincident commit.
                    if (!pend) begin
                        state <= IDLE;
                    end else if (i_inst_commit) begin
                        state        <= REQ;
                        epc_q        <= i_commit_next_pc;
                        o_trap_req   <= 1'b1;
                        o_trap_cause <= CAUSE_MTI;
                        o_trap_epc   <= i_commit_next_pc;
                    end
                end
                REQ: begin
                    // Once committed, the request ignores enable and mtip changes.
                    if (i_trap_ack) begin
                        state        <= INSVC;
                        o_trap_req   <= 1'b0;
                        o_trap_cause <= 64'd0;
                        o_trap_epc   <= 64'd0;
                        o_in_service <= 1'b1;
                        if (count_q != 32'hFFFF_FFFF) begin
                            count_q <= count_q + 32'd1;
                        end
                    end
                end
                INSVC: begin
                    if (i_mret) begin
                        state        <= IDLE;
                        o_in_service <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ysyx_210544_intr_ctrl.sv
// Directed bench for the machine-timer interrupt controller.
// Each scenario task drives inputs just after a rising edge and checks the registered outputs there.
module tb_ysyx_210544_intr_ctrl;

    localparam logic [1:0]  S_IDLE  = 2'd0;
    localparam logic [1:0]  S_ARMED = 2'd1;
    localparam logic [1:0]  S_REQ   = 2'd2;
    localparam logic [1:0]  S_INSVC = 2'd3;
    localparam logic [63:0] CAUSE   = 64'h8000_0000_0000_0007;

    logic        clk;
    logic        rst;
    logic        i_mtime_overflow;
    logic        i_csr_mstatus_mie;
    logic        i_csr_mie_mtie;
    logic        i_inst_commit;
    logic [63:0] i_commit_next_pc;
    logic        i_trap_ack;
    logic        i_mret;
    logic        o_mip_mtip;
    logic        o_trap_req;
    logic [63:0] o_trap_cause;
    logic [63:0] o_trap_epc;
    logic        o_in_service;
    logic [31:0] o_intr_count;

    int checks = 0;
    int errors = 0;

    ysyx_210544_intr_ctrl dut (
        .clk               (clk),
        .rst               (rst),
        .i_mtime_overflow  (i_mtime_overflow),
        .i_csr_mstatus_mie (i_csr_mstatus_mie),
        .i_csr_mie_mtie    (i_csr_mie_mtie),
        .i_inst_commit     (i_inst_commit),
        .i_commit_next_pc  (i_commit_next_pc),
        .i_trap_ack        (i_trap_ack),
        .i_mret            (i_mret),
        .o_mip_mtip        (o_mip_mtip),
        .o_trap_req        (o_trap_req),
        .o_trap_cause      (o_trap_cause),
        .o_trap_epc        (o_trap_epc),
        .o_in_service      (o_in_service),
        .o_intr_count      (o_intr_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
        checks++; if (o_trap_req !== 1'b0) begin errors++; $display("[TB] FAIL reset_req: got %b expected 0", o_trap_req); end
        checks++; if (o_trap_cause !== 64'd0) begin errors++; $display("[TB] FAIL reset_cause: got %h expected 0", o_trap_cause); end
        checks++; if (o_trap_epc !== 64'd0) begin errors++; $display("[TB] FAIL reset_epc: got %h expected 0", o_trap_epc); end
        checks++; if (o_in_service !== 1'b0) begin errors++; $display("[TB] FAIL reset_insvc: got %b expected 0", o_in_service); end
        checks++; if (o_mip_mtip !== 1'b0) begin errors++; $display("[TB] FAIL reset_mtip: got %b expected 0", o_mip_mtip); end
        checks++; if (o_intr_count !== 32'd0) begin errors++; $display("[TB] FAIL reset_count: got %0d expected 0", o_intr_count); end
        tick(3);
        checks++; if (dut.state !== S_IDLE) begin errors++; $display("[TB] FAIL idle_state: got %0d expected %0d", dut.state, S_IDLE); end
    endtask

    task automatic test_basic_trap;
        i_csr_mstatus_mie = 1'b1;
        i_csr_mie_mtie    = 1'b1;
        i_mtime_overflow  = 1'b1;
        tick();
        checks++; if (o_mip_mtip !== 1'b1) begin errors++; $display("[TB] FAIL basic_mtip: got %b expected 1", o_mip_mtip); end
        checks++; if (dut.state !== S_IDLE) begin errors++; $display("[TB] FAIL basic_not_yet_armed: got %0d expected %0d", dut.state, S_IDLE); end
        tick();
        checks++; if (dut.state !== S_ARMED) begin errors++; $display("[TB] FAIL basic_armed: got %0d expected %0d", dut.state, S_ARMED); end
        tick();
        checks++; if (o_trap_req !== 1'b0) begin errors++; $display("[TB] FAIL basic_wait_commit: got %b expected 0", o_trap_req); end
        i_inst_commit    = 1'b1;
        i_commit_next_pc = 64'h8000_0100;
        tick();
        i_inst_commit    = 1'b0;
        i_commit_next_pc = 64'hDEAD_BEEF;
        checks++; if (o_trap_req !== 1'b1) begin errors++; $display("[TB] FAIL basic_req: got %b expected 1", o_trap_req); end
        checks++; if (o_trap_cause !== CAUSE) begin errors++; $display("[TB] FAIL basic_cause: got %h expected %h", o_trap_cause, CAUSE); end
        checks++; if (o_trap_epc !== 64'h8000_0100) begin errors++; $display("[TB] FAIL basic_epc: got %h expected 8000_0100", o_trap_epc); end
        // Dropping enables and mtip while the request is outstanding must not retract it.
        i_csr_mstatus_mie = 1'b0;
        i_mtime_overflow  = 1'b0;
        tick(2);
        checks++; if (o_trap_req !== 1'b1) begin errors++; $display("[TB] FAIL basic_req_held: got %b expected 1", o_trap_req); end
        checks++; if (o_trap_epc !== 64'h8000_0100) begin errors++; $display("[TB] FAIL basic_epc_held: got %h expected 8000_0100", o_trap_epc); end
        i_csr_mstatus_mie = 1'b1;
        i_mtime_overflow  = 1'b1;
        i_trap_ack        = 1'b1;
        tick();
        i_trap_ack = 1'b0;
        checks++; if (o_trap_req !== 1'b0) begin errors++; $display("[TB] FAIL basic_req_fall: got %b expected 0", o_trap_req); end
        checks++; if (o_trap_cause !== 64'd0) begin errors++; $display("[TB] FAIL basic_cause_clear: got %h expected 0", o_trap_cause); end
        checks++; if (o_trap_epc !== 64'd0) begin errors++; $display("[TB] FAIL basic_epc_clear: got %h expected 0", o_trap_epc); end
        checks++; if (o_in_service !== 1'b1) begin errors++; $display("[TB] FAIL basic_insvc: got %b expected 1", o_in_service); end
        checks++; if (o_intr_count !== 32'd1) begin errors++; $display("[TB] FAIL basic_count: got %0d expected 1", o_intr_count); end
    endtask

    task automatic test_service_rearm;
        int req_seen = 0;
        for (int i = 0; i < 6; i++) begin
            i_inst_commit = i[0];
            i_trap_ack    = 1'b1;
            tick();
            if (o_trap_req) req_seen++;
        end
        i_inst_commit = 1'b0;
        i_trap_ack    = 1'b0;
        checks++; if (req_seen !== 0) begin errors++; $display("[TB] FAIL insvc_block: got %0d req cycles expected 0", req_seen); end
        checks++; if (o_intr_count !== 32'd1) begin errors++; $display("[TB] FAIL insvc_ack_ignored: got %0d expected 1", o_intr_count); end
        i_mret = 1'b1;
        tick();
        i_mret = 1'b0;
        checks++; if (dut.state !== S_IDLE) begin errors++; $display("[TB] FAIL mret_idle: got %0d expected %0d", dut.state, S_IDLE); end
        checks++; if (o_in_service !== 1'b0) begin errors++; $display("[TB] FAIL mret_insvc: got %b expected 0", o_in_service); end
        tick();
        checks++; if (dut.state !== S_ARMED) begin errors++; $display("[TB] FAIL rearm: got %0d expected %0d", dut.state, S_ARMED); end
        i_inst_commit    = 1'b1;
        i_commit_next_pc = 64'h8000_0200;
        tick();
        i_inst_commit = 1'b0;
        checks++; if (o_trap_epc !== 64'h8000_0200) begin errors++; $display("[TB] FAIL rearm_epc: got %h expected 8000_0200", o_trap_epc); end
        i_trap_ack = 1'b1;
        tick();
        i_trap_ack = 1'b0;
        checks++; if (o_intr_count !== 32'd2) begin errors++; $display("[TB] FAIL rearm_count: got %0d expected 2", o_intr_count); end
        i_mret           = 1'b1;
        i_mtime_overflow = 1'b0;
        tick();
        i_mret = 1'b0;
        tick(2);
        checks++; if (dut.state !== S_IDLE) begin errors++; $display("[TB] FAIL quiesce_idle: got %0d expected %0d", dut.state, S_IDLE); end
    endtask

    task automatic test_enable_gating;
        int req_seen = 0;
        i_csr_mie_mtie   = 1'b0;
        i_mtime_overflow = 1'b1;
        for (int i = 0; i < 50; i++) begin
            i_inst_commit    = i[0];
            i_commit_next_pc = 64'h8000_0000 + 64'(i);
            tick();
            if (o_trap_req) req_seen++;
        end
        i_inst_commit = 1'b0;
        checks++; if (req_seen !== 0) begin errors++; $display("[TB] FAIL gate_no_req: got %0d req cycles expected 0", req_seen); end
        checks++; if (o_mip_mtip !== 1'b1) begin errors++; $display("[TB] FAIL gate_mtip: got %b expected 1", o_mip_mtip); end
        i_csr_mie_mtie = 1'b1;
        tick();
        checks++; if (dut.state !== S_ARMED) begin errors++; $display("[TB] FAIL gate_armed: got %0d expected %0d", dut.state, S_ARMED); end
        i_inst_commit    = 1'b1;
        i_commit_next_pc = 64'h8000_0300;
        tick();
        i_inst_commit = 1'b0;
        checks++; if (o_trap_req !== 1'b1 || o_trap_epc !== 64'h8000_0300) begin
            errors++; $display("[TB] FAIL gate_req: got req=%b epc=%h expected req=1 epc=8000_0300", o_trap_req, o_trap_epc);
        end
        i_trap_ack = 1'b1;
        tick();
        i_trap_ack       = 1'b0;
        i_mret           = 1'b1;
        i_mtime_overflow = 1'b0;
        tick();
        i_mret = 1'b0;
        tick(2);
        checks++; if (o_intr_count !== 32'd3) begin errors++; $display("[TB] FAIL gate_count: got %0d expected 3", o_intr_count); end
    endtask

    task automatic test_drop_while_armed;
        int req_seen = 0;
        i_mtime_overflow = 1'b1;
        tick();
        // Commit coincident with arming is not used for the request.
        i_inst_commit    = 1'b1;
        i_commit_next_pc = 64'h8000_0400;
        tick();
        i_inst_commit = 1'b0;
        checks++; if (dut.state !== S_ARMED || o_trap_req !== 1'b0) begin
            errors++; $display("[TB] FAIL arm_commit_ignored: got state=%0d req=%b expected state=%0d req=0", dut.state, o_trap_req, S_ARMED);
        end
        // Losing the enable has priority over a commit in the same cycle.
        i_csr_mstatus_mie = 1'b0;
        i_inst_commit     = 1'b1;
        tick();
        checks++; if (dut.state !== S_IDLE || o_trap_req !== 1'b0) begin
            errors++; $display("[TB] FAIL drop_priority: got state=%0d req=%b expected state=%0d req=0", dut.state, o_trap_req, S_IDLE);
        end
        for (int i = 0; i < 6; i++) begin
            i_inst_commit = i[0];
            tick();
            if (o_trap_req) req_seen++;
        end
        i_inst_commit    = 1'b0;
        i_mtime_overflow = 1'b0;
        checks++; if (req_seen !== 0) begin errors++; $display("[TB] FAIL drop_no_req: got %0d req cycles expected 0", req_seen); end
        checks++; if (o_intr_count !== 32'd3) begin errors++; $display("[TB] FAIL drop_count: got %0d expected 3", o_intr_count); end
        tick(2);
        i_csr_mstatus_mie = 1'b1;
        tick();
    endtask

    task automatic test_reset_mid_request;
        i_mtime_overflow = 1'b1;
        tick(2);
        i_inst_commit    = 1'b1;
        i_commit_next_pc = 64'h8000_0500;
        tick();
        i_inst_commit = 1'b0;
        checks++; if (o_trap_req !== 1'b1) begin errors++; $display("[TB] FAIL midreq_setup: got %b expected 1", o_trap_req); end
        rst              = 1'b1;
        i_mtime_overflow = 1'b0;
        i_trap_ack       = 1'b1;
        tick();
        rst        = 1'b0;
        i_trap_ack = 1'b0;
        checks++; if (o_trap_req !== 1'b0 || dut.state !== S_IDLE) begin
            errors++; $display("[TB] FAIL midreq_abandon: got req=%b state=%0d expected req=0 state=%0d", o_trap_req, dut.state, S_IDLE);
        end
        checks++; if (o_trap_epc !== 64'd0 || o_trap_cause !== 64'd0) begin
            errors++; $display("[TB] FAIL midreq_clear: got epc=%h cause=%h expected 0", o_trap_epc, o_trap_cause);
        end
        checks++; if (o_intr_count !== 32'd0) begin errors++; $display("[TB] FAIL midreq_count: got %0d expected 0", o_intr_count); end
        tick(2);
    endtask

    task automatic test_saturation;
        force dut.count_q = 32'hFFFF_FFFF;
        tick();
        release dut.count_q;
        i_mtime_overflow = 1'b1;
        tick(2);
        i_inst_commit    = 1'b1;
        i_commit_next_pc = 64'h8000_0600;
        tick();
        i_inst_commit = 1'b0;
        i_trap_ack    = 1'b1;
        tick();
        i_trap_ack = 1'b0;
        checks++; if (o_intr_count !== 32'hFFFF_FFFF) begin errors++; $display("[TB] FAIL saturate: got %h expected ffffffff", o_intr_count); end
        checks++; if (o_in_service !== 1'b1) begin errors++; $display("[TB] FAIL saturate_insvc: got %b expected 1", o_in_service); end
    endtask

    initial begin
        rst               = 1'b1;
        i_mtime_overflow  = 1'b0;
        i_csr_mstatus_mie = 1'b0;
        i_csr_mie_mtie    = 1'b0;
        i_inst_commit     = 1'b0;
        i_commit_next_pc  = 64'd0;
        i_trap_ack        = 1'b0;
        i_mret            = 1'b0;
        test_reset();
        test_basic_trap();
        test_service_rearm();
        test_enable_gating();
        test_drop_while_armed();
        test_reset_mid_request();
        test_saturation();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
